// File: rtl/gmii_tx_framer_if.sv
// Payload stream into the GMII transmit framer.
//   s_valid : payload byte valid            (source -> framer)
//   s_data  : payload byte                  (source -> framer)
//   s_last  : final payload byte of a frame (source -> framer)
//   s_ready : framer takes the byte         (framer -> source)
// master = payload source, slave = framer.
interface gmii_tx_framer_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;
   logic       s_ready;

   modport master (output s_valid, s_data, s_last, input s_ready);
   modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// Ethernet transmit framer feeding the GMII-to-RGMII DDR output stage.
// Wraps a byte payload stream into a GMII frame: 7x 0x55 preamble, 0xD5 SFD,
// payload, optional zero pad, CRC-32 FCS (LSB first), then an idle gap.
// A payload gap (s_valid low before s_last) aborts the frame with an
// inverted FCS so the far end discards it.
//
// Optional feature: define GMII_TX_PAD_EN to zero-pad short frames up to
// MIN_PAYLOAD bytes. Without it there is no PAD state and MIN_PAYLOAD is
// ignored.
//
// Ports:
//   gmii_txc    : 125 MHz transmit clock (only clock)
//   rst_n       : asynchronous active-low reset
//   s           : payload stream (slave side of gmii_tx_framer_if)
//   gmii_tx_dv  : GMII transmit enable (registered)
//   gmii_td     : GMII transmit data (registered)
//   tx_busy     : high whenever not IDLE
//   tx_underrun : one-cycle pulse when a frame is aborted by a payload gap
module gmii_tx_framer #(
   parameter int IFG_BYTES   = 12,
   parameter int MIN_PAYLOAD = 46
) (
   input  logic             gmii_txc,
   input  logic             rst_n,
   gmii_tx_framer_if.slave  s,
   output logic             gmii_tx_dv,
   output logic [7:0]       gmii_td,
   output logic             tx_busy,
   output logic             tx_underrun
);

   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   // IFG state lasts IFG_BYTES-1 cycles; the IDLE cycle that samples
   // s_valid supplies the last idle cycle on the wire.
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 2);
`ifdef GMII_TX_PAD_EN
   localparam logic [10:0] MIN_P = 11'(MIN_PAYLOAD);
`endif

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
`ifdef GMII_TX_PAD_EN
      PAD,
`endif
      FCS,
      IFG
   } state_t;

   state_t      state;
   logic [15:0] ph;        // phase counter shared by PRE / FCS / IFG
   logic [10:0] pay_cnt;   // payload+pad bytes, saturating
   logic [31:0] crc;
   logic        bad;       // frame aborted: send FCS uninverted

   logic [10:0] cnt_inc;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      return r;
   endfunction

   assign cnt_inc  = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;
   assign fcs_word = bad ? crc : ~crc;

   always_comb begin
      fcs_byte = fcs_word[7:0];
      case (ph[1:0])
         2'd1:    fcs_byte = fcs_word[15:8];
         2'd2:    fcs_byte = fcs_word[23:16];
         2'd3:    fcs_byte = fcs_word[31:24];
         default: fcs_byte = fcs_word[7:0];
      endcase
   end

   assign s.s_ready = (state == DATA);
   assign tx_busy   = (state != IDLE);

   always_ff @(posedge gmii_txc or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ph          <= '0;
         pay_cnt     <= '0;
         crc         <= '0;
         bad         <= 1'b0;
         gmii_tx_dv  <= 1'b0;
         gmii_td     <= 8'h00;
         tx_underrun <= 1'b0;
      end else begin
         gmii_tx_dv  <= 1'b0;
         gmii_td     <= 8'h00;
         tx_underrun <= 1'b0;
         case (state)
            IDLE: begin
               // the pending byte stays with the source until DATA
               if (s.s_valid) begin
                  state <= PRE;
                  ph    <= '0;
               end
            end
            PRE: begin
               gmii_tx_dv <= 1'b1;
               gmii_td    <= 8'h55;
               ph         <= ph + 16'd1;
               if (ph == 16'd6) state <= SFD;
            end
            SFD: begin
               gmii_tx_dv <= 1'b1;
               gmii_td    <= 8'hD5;
               crc        <= 32'hFFFF_FFFF;
               pay_cnt    <= '0;
               bad        <= 1'b0;
               ph         <= '0;
               state      <= DATA;
            end
            DATA: begin
               gmii_tx_dv <= 1'b1;
               if (s.s_valid) begin
                  gmii_td <= s.s_data;
                  crc     <= crc_byte(crc, s.s_data);
                  pay_cnt <= cnt_inc;
                  if (s.s_last) begin
                     ph <= '0;
`ifdef GMII_TX_PAD_EN
                     state <= (cnt_inc < MIN_P) ? PAD : FCS;
`else
                     state <= FCS;
`endif
                  end
               end else begin
                  // Underrun: first FCS byte goes out this very cycle so
                  // tx_dv stays contiguous. crc[7:0] is the inverse of the
                  // correct FCS byte (~crc); bad keeps the rest inverted.
                  tx_underrun <= 1'b1;
                  bad         <= 1'b1;
                  gmii_td     <= crc[7:0];
                  ph          <= 16'd1;
                  state       <= FCS;
               end
            end
`ifdef GMII_TX_PAD_EN
            PAD: begin
               gmii_tx_dv <= 1'b1;
               gmii_td    <= 8'h00;
               crc        <= crc_byte(crc, 8'h00);
               pay_cnt    <= cnt_inc;
               if (cnt_inc == MIN_P) begin
                  ph    <= '0;
                  state <= FCS;
               end
            end
`endif
            FCS: begin
               gmii_tx_dv <= 1'b1;
               gmii_td    <= fcs_byte;
               ph         <= ph + 16'd1;
               if (ph == 16'd3) begin
                  ph    <= '0;
                  state <= (IFG_BYTES > 1) ? IFG : IDLE;
               end
            end
            IFG: begin
               ph <= ph + 16'd1;
               if (ph == IFG_LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
